phy_rx_deskew_unstripe: RTL and testbench
=========================================

# phy_rx_deskew_unstripe

Parametrised multi-lane receive back end of the PHY layer. It takes byte-wide, already-deserialised data from 1, 2 or 4 lanes and performs three jobs:
- removes inter-lane skew using a COM alignment symbol and per-lane deskew FIFOs;
- unstripes the lanes back into a single 32-bit word stream;
- reports alignment and skew/overflow errors.

It runs entirely in the byte-clock domain. It replaces the fixed two-lane, multi-clock unstriping path.

## Interface
Parameters:
- LANES, 2, number of lanes; legal values 1, 2, 4.
- DEPTH, 4, per-lane deskew FIFO depth in bytes; power of 2, at least 2. Also the maximum tolerated skew plus 1, in cycles.
- COM, 8'hBC, alignment symbol.

Ports:
- clk_4f, input, 1, byte clock. All logic is on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- data_in, input, 8*LANES, lane i occupies bits [8i+7:8i].
- valid_in, input, LANES, per-lane byte-valid.
- data_out, output, 32, assembled word, registered.
- valid_out, output, 1, one-cycle strobe per new word.
- aligned, output, 1, high while in DATA.
- skew_err, output, 1, one-cycle pulse on alignment timeout or FIFO overflow.

## Operation
- Reset values: data_out=0, valid_out=0, aligned=0, skew_err=0. The FSM is in SEARCH, all FIFOs are empty, lane-found flags are cleared, the word assembler is empty, and the skew counter is 0.

SEARCH state:
- FIFOs take no writes.
- A byte with valid_in[i]=1 and value COM sets found[i].
- The first found flag set starts skew_cnt. The -> ALIGN transition happens on that same edge.

ALIGN state:
- Lane i with found[i]=1 pushes every subsequent valid non-COM byte into FIFO i. The COM byte itself is never stored.
- Lanes not yet found keep watching for COM.
- skew_cnt increments every cycle.
- When all found flags are 1 (including flags set on this edge): -> DATA.
- If skew_cnt reaches DEPTH-1 with any lane still unfound: skew_err pulses, all FIFOs and flags are flushed, -> SEARCH.

DATA state:
- Valid non-COM bytes push into their lane FIFO.
- Valid COM bytes are dropped on every lane; there is no realignment in DATA.
- Pop rule: when every FIFO is non-empty, one byte is popped from every lane on the same edge.
- A push to a full FIFO is an overflow: skew_err pulses, everything is flushed (including a partial word), aligned drops, -> SEARCH.

Unstriping order:
- Pop k delivers stream bytes k*LANES+i for lanes i=0..LANES-1.
- Words are assembled MSB-first: stream byte 0 goes to data_out[31:24] and byte 3 goes to data_out[7:0].
- A word is complete after 4/LANES pops.

Word output:
- On the completing pop, data_out loads the word and valid_out=1 for one cycle.
- data_out holds its value between strobes.

Width rules:
- skew_cnt is clog2(DEPTH) bits and saturates.
- FIFO pointers are clog2(DEPTH)+1 bits, so full and empty are distinguished by the MSB.

## Timing
- Zero-skew latency: the edge that samples the last byte of a word is edge E. The completing pop and the data_out/valid_out update occur on edge E+1, i.e. one cycle of FIFO latency.
- With lane skew s (0 ≤ s ≤ DEPTH-2), the pop waits for the latest lane, so latency is measured from that lane's sample edge. Output throughput is then unaffected by s.
- A simultaneous push and pop on the same FIFO is legal when the FIFO is full; this is not an overflow.
- Asynchronous reset mid-word discards the partial word. Outputs return to their reset values immediately, without waiting for a clock edge.
- Gaps: valid_in low on a lane inserts no byte, which simply stalls pops. Gaps on different lanes may differ by at most DEPTH-1 bytes.
- skew_err and the -> SEARCH transition occur on the same edge. A COM sampled on that same edge is ignored.

## Test plan
- LANES=2, zero skew: COM on both lanes, then lane0=11,33 and lane1=22,44 on consecutive cycles -> a single valid_out pulse with data_out=32'h11223344, and aligned=1 from the cycle after COM.
- LANES=4, DEPTH=4: lane 3 delayed by 2 cycles relative to lanes 0-2, payload AA,BB,CC,DD -> data_out=32'hAABBCCDD with no skew_err.
- LANES=2, DEPTH=4: lane 1 COM arrives 4 cycles after lane 0 -> skew_err pulses once and aligned stays 0. A later aligned COM pair then recovers normally.
- LANES=2 in DATA, with COM inserted mid-stream on both lanes -> COM bytes absent from the output and word boundaries unaffected.
- LANES=1, DEPTH=2: stall pops by holding the other lane... use LANES=2, with lane 0 sending 3 bytes while lane 1 is idle -> overflow, skew_err pulse, aligned=0.
- Assert reset after 2 of 4 bytes of a word (LANES=1) -> outputs 0 immediately. After realignment, the next word contains no stale bytes.

Source files
------------

// File: rtl/phy_rx_deskew_unstripe.sv
// phy_rx_deskew_unstripe
//   Multi-lane PHY receive back end in the byte-clock domain. Aligns 1, 2 or
//   4 byte lanes on a COM symbol using per-lane deskew FIFOs, unstripes the
//   lanes into a 32-bit word stream (stream byte 0 in data_out[31:24]) and
//   flags alignment timeouts and FIFO overflows.
//
//   Ports:
//     clk_4f    - byte clock, all logic on the rising edge
//     reset     - asynchronous, active-high; clears all state
//     data_in   - LANES bytes, lane i in [8i+7:8i]
//     valid_in  - per-lane byte valid
//     data_out  - assembled 32-bit word, registered, held between strobes
//     valid_out - one-cycle strobe per completed word
//     aligned   - high while the lanes are aligned (DATA state)
//     skew_err  - one-cycle pulse on alignment timeout or FIFO overflow
module phy_rx_deskew_unstripe #(
   parameter int         LANES = 2,
   parameter int         DEPTH = 4,
   parameter logic [7:0] COM   = 8'hBC
) (
   input  logic                 clk_4f,
   input  logic                 reset,
   input  logic [8*LANES-1:0]   data_in,
   input  logic [LANES-1:0]     valid_in,
   output logic [31:0]          data_out,
   output logic                 valid_out,
   output logic                 aligned,
   output logic                 skew_err
);

   localparam int unsigned      NL       = LANES;
   localparam int               AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]    SKEW_MAX = AW'(DEPTH - 1);
   localparam logic [1:0]       LAST_POP = 2'(4 / LANES - 1);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_ALIGN  = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;

   logic [1:0]       state;
   logic [LANES-1:0] found;
   logic [AW-1:0]    skew_cnt;
   logic [AW:0]      wr_ptr [LANES];
   logic [AW:0]      rd_ptr [LANES];
   logic [7:0]       mem    [LANES][DEPTH];
   logic [1:0]       pop_cnt;
   logic [31:0]      word_buf;

   logic [7:0]       lane_byte [LANES];
   logic [7:0]       rd_byte   [LANES];
   logic [LANES-1:0] com_hit, byte_ok, push, empty, full;
   logic [31:0]      word_next;
   logic             pop, timeout, overflow, flush, all_found_now;

   always_comb begin
      lane_byte = '{default: '0};
      rd_byte   = '{default: '0};
      com_hit   = '0;
      byte_ok   = '0;
      empty     = '0;
      full      = '0;
      for (int unsigned i = 0; i < NL; i++) begin
         lane_byte[i] = data_in[8*i +: 8];
         com_hit[i]   = valid_in[i] && (lane_byte[i] == COM);
         byte_ok[i]   = valid_in[i] && (lane_byte[i] != COM);
         empty[i]     = (wr_ptr[i] == rd_ptr[i]);
         // Pointer MSBs differ while the low bits match: FIFO holds DEPTH bytes.
         full[i]      = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                        (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
         rd_byte[i]   = mem[i][rd_ptr[i][AW-1:0]];
      end

      all_found_now = &(found | com_hit);
      pop      = (state == ST_DATA) && (&(~empty));
      // The timeout decision ignores any COM arriving on the same edge.
      timeout  = (state == ST_ALIGN) && (skew_cnt == SKEW_MAX) && !(&found);

      case (state)
         ST_ALIGN: push = timeout ? '0 : (found & byte_ok);
         ST_DATA:  push = byte_ok;
         default:  push = '0;
      endcase

      // A push into a full FIFO is only safe when that FIFO pops on the same edge.
      overflow = (state == ST_DATA) && (|(push & full)) && !pop;
      flush    = timeout || overflow;

      // Pop k places lane i at stream byte k*LANES+i, MSB-first in the word.
      word_next = word_buf;
      for (int unsigned i = 0; i < NL; i++) begin
         word_next[8*(3 - (32'(pop_cnt)*NL + i)) +: 8] = rd_byte[i];
      end
   end

   assign aligned = (state == ST_DATA);

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state     <= ST_SEARCH;
         found     <= '0;
         skew_cnt  <= '0;
         pop_cnt   <= '0;
         word_buf  <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         skew_err  <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         skew_err  <= 1'b0;

         case (state)
            ST_SEARCH: begin
               if (|com_hit) begin
                  found    <= com_hit;
                  skew_cnt <= '0;
                  state    <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (timeout) begin
                  skew_err <= 1'b1;
                  found    <= '0;
                  state    <= ST_SEARCH;
               end else begin
                  found <= found | com_hit;
                  if (skew_cnt != SKEW_MAX) skew_cnt <= skew_cnt + AW'(1);
                  if (all_found_now) state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (overflow) begin
                  skew_err <= 1'b1;
                  found    <= '0;
                  state    <= ST_SEARCH;
               end
            end
            default: state <= ST_SEARCH;
         endcase

         if (flush) begin
            pop_cnt  <= '0;
            word_buf <= '0;
         end else if (pop) begin
            if (pop_cnt == LAST_POP) begin
               data_out  <= word_next;
               valid_out <= 1'b1;
               pop_cnt   <= '0;
            end else begin
               word_buf <= word_next;
               pop_cnt  <= pop_cnt + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NL; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NL; i++) begin
            if (flush) begin
               wr_ptr[i] <= '0;
               rd_ptr[i] <= '0;
            end else begin
               if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
               if (pop)     rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_4f) begin
      for (int unsigned i = 0; i < NL; i++) begin
         if (push[i] && !flush) mem[i][wr_ptr[i][AW-1:0]] <= lane_byte[i];
      end
   end

endmodule

// File: tb/tb_phy_rx_deskew_unstripe.sv
// tb_phy_rx_deskew_unstripe
//   Directed bench for phy_rx_deskew_unstripe. Four instances share clock and
//   reset: 2 lanes/depth 4, 4 lanes/depth 4, 2 lanes/depth 2 and 1 lane/depth 4.
//   Inputs change 1 time unit after each rising edge; outputs are checked at
//   the same point, reflecting the edge just taken.
module tb_phy_rx_deskew_unstripe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [15:0] d2;  logic [1:0] v2;  logic [31:0] q2;  logic vo2, al2, se2;
   logic [31:0] d4;  logic [3:0] v4;  logic [31:0] q4;  logic vo4, al4, se4;
   logic [15:0] ds;  logic [1:0] vs;  logic [31:0] qs;  logic vos, als, ses;
   logic [7:0]  d1;  logic [0:0] v1;  logic [31:0] q1;  logic vo1, al1, se1;

   int errs   = 0;
   int checks = 0;

   phy_rx_deskew_unstripe #(.LANES(2), .DEPTH(4), .COM(8'hBC)) u2 (
      .clk_4f(clk), .reset(rst), .data_in(d2), .valid_in(v2),
      .data_out(q2), .valid_out(vo2), .aligned(al2), .skew_err(se2));

   phy_rx_deskew_unstripe #(.LANES(4), .DEPTH(4), .COM(8'hBC)) u4 (
      .clk_4f(clk), .reset(rst), .data_in(d4), .valid_in(v4),
      .data_out(q4), .valid_out(vo4), .aligned(al4), .skew_err(se4));

   phy_rx_deskew_unstripe #(.LANES(2), .DEPTH(2), .COM(8'hBC)) us (
      .clk_4f(clk), .reset(rst), .data_in(ds), .valid_in(vs),
      .data_out(qs), .valid_out(vos), .aligned(als), .skew_err(ses));

   phy_rx_deskew_unstripe #(.LANES(1), .DEPTH(4), .COM(8'hBC)) u1 (
      .clk_4f(clk), .reset(rst), .data_in(d1), .valid_in(v1),
      .data_out(q1), .valid_out(vo1), .aligned(al1), .skew_err(se1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      d2 = '0; v2 = '0; d4 = '0; v4 = '0; ds = '0; vs = '0; d1 = '0; v1 = '0;
      #1;
      chk("rst_async_q2", q2, 32'h0);
      chk("rst_async_vo2", {31'b0, vo2}, 32'h0);
      tick(); tick();
      chk("rst_q2", q2, 32'h0);
      chk("rst_vo2", {31'b0, vo2}, 32'h0);
      chk("rst_al2", {31'b0, al2}, 32'h0);
      chk("rst_se2", {31'b0, se2}, 32'h0);
      chk("rst_q4", q4, 32'h0);
      chk("rst_al1", {31'b0, al1}, 32'h0);
      rst = 1'b0;
      tick();

      // ---- 2 lanes: lane1 COM four cycles after lane0 -> timeout ----
      d2 = 16'h00BC; v2 = 2'b01;                  // E0: lane0 COM
      tick();
      chk("t3_e0_al", {31'b0, al2}, 32'h0);
      for (int k = 1; k <= 3; k++) begin          // E1..E3: lane0 payload only
         d2 = {8'h00, 8'(k)}; v2 = 2'b01;
         tick();
         chk("t3_no_early_err", {31'b0, se2}, 32'h0);
      end
      d2 = 16'hBC00; v2 = 2'b10;                  // E4: lane1 COM, too late
      tick();
      chk("t3_err_pulse", {31'b0, se2}, 32'h1);
      chk("t3_err_al", {31'b0, al2}, 32'h0);
      d2 = '0; v2 = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t3_single_pulse", {31'b0, se2}, 32'h0);
         chk("t3_al_low", {31'b0, al2}, 32'h0);
      end

      // ---- 2 lanes: aligned COM pair, zero skew, word 11223344 ----
      d2 = 16'hBCBC; v2 = 2'b11;                  // E0
      tick();
      chk("t1_e0_al", {31'b0, al2}, 32'h0);
      d2 = 16'h2211; v2 = 2'b11;                  // E1: -> DATA
      tick();
      chk("t1_e1_al", {31'b0, al2}, 32'h1);
      chk("t1_e1_vo", {31'b0, vo2}, 32'h0);
      d2 = 16'h4433; v2 = 2'b11;                  // E2: first pop
      tick();
      chk("t1_e2_vo", {31'b0, vo2}, 32'h0);
      d2 = '0; v2 = '0;                           // E3: completing pop
      tick();
      chk("t1_vo", {31'b0, vo2}, 32'h1);
      chk("t1_q", q2, 32'h11223344);
      chk("t1_se", {31'b0, se2}, 32'h0);
      tick();                                     // E4: strobe ends, data holds
      chk("t1_vo_one_cycle", {31'b0, vo2}, 32'h0);
      chk("t1_q_hold", q2, 32'h11223344);

      // ---- 2 lanes in DATA: COM pair mid-word is dropped ----
      d2 = 16'h6655; v2 = 2'b11;
      tick();
      d2 = 16'hBCBC; v2 = 2'b11;
      tick();
      chk("t4_com_vo", {31'b0, vo2}, 32'h0);
      d2 = 16'h8877; v2 = 2'b11;
      tick();
      chk("t4_gap_vo", {31'b0, vo2}, 32'h0);
      d2 = '0; v2 = '0;
      tick();
      chk("t4_vo", {31'b0, vo2}, 32'h1);
      chk("t4_q", q2, 32'h55667788);
      chk("t4_al", {31'b0, al2}, 32'h1);

      // ---- 4 lanes: lane3 two cycles late, back-to-back words ----
      d4 = 32'h00BCBCBC; v4 = 4'b0111;            // E0
      tick();
      d4 = 32'h00CCBBAA; v4 = 4'b0111;            // E1
      tick();
      chk("t2_e1_al", {31'b0, al4}, 32'h0);
      d4 = 32'hBC332211; v4 = 4'b1111;            // E2: lane3 COM -> DATA
      tick();
      chk("t2_e2_al", {31'b0, al4}, 32'h1);
      d4 = 32'hDD000000; v4 = 4'b1000;            // E3
      tick();
      chk("t2_e3_vo", {31'b0, vo4}, 32'h0);
      d4 = 32'h44000000; v4 = 4'b1000;            // E4: pop word 0
      tick();
      chk("t2_vo0", {31'b0, vo4}, 32'h1);
      chk("t2_q0", q4, 32'hAABBCCDD);
      d4 = '0; v4 = '0;                           // E5: pop word 1
      tick();
      chk("t2_vo1", {31'b0, vo4}, 32'h1);
      chk("t2_q1", q4, 32'h11223344);
      chk("t2_se", {31'b0, se4}, 32'h0);

      // ---- 2 lanes, depth 2: lane0 sends 3 bytes, lane1 idle -> overflow ----
      ds = 16'hBCBC; vs = 2'b11;
      tick();
      ds = 16'h0001; vs = 2'b01;
      tick();
      chk("t5_al", {31'b0, als}, 32'h1);
      ds = 16'h0002; vs = 2'b01;
      tick();
      chk("t5_full_no_err", {31'b0, ses}, 32'h0);
      ds = 16'h0003; vs = 2'b01;
      tick();
      chk("t5_err", {31'b0, ses}, 32'h1);
      chk("t5_al_drop", {31'b0, als}, 32'h0);
      ds = '0; vs = '0;
      tick();
      chk("t5_err_one_cycle", {31'b0, ses}, 32'h0);
      chk("t5_vo", {31'b0, vos}, 32'h0);

      // ---- 1 lane: full word, then reset after 2 bytes of the next ----
      d1 = 8'hBC; v1 = 1'b1;
      tick();
      for (int k = 1; k <= 6; k++) begin
         d1 = 8'(k); v1 = 1'b1;
         tick();
         if (k == 5) begin
            chk("t6_vo", {31'b0, vo1}, 32'h1);
            chk("t6_q", q1, 32'h01020304);
         end
      end
      d1 = '0; v1 = '0;
      tick();
      chk("t6_partial_vo", {31'b0, vo1}, 32'h0);
      chk("t6_q_hold", q1, 32'h01020304);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_q", q1, 32'h0);
      chk("t6_rst_al", {31'b0, al1}, 32'h0);
      chk("t6_rst_vo", {31'b0, vo1}, 32'h0);
      tick();
      rst = 1'b0;
      d1 = 8'hBC; v1 = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         d1 = 8'(8'h0A + k); v1 = 1'b1;
         tick();
         chk("t6_no_stale_vo", {31'b0, vo1}, 32'h0);
      end
      d1 = '0; v1 = '0;
      tick();
      chk("t6_realign_vo", {31'b0, vo1}, 32'h1);
      chk("t6_realign_q", q1, 32'h0A0B0C0D);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
